// File: rtl/control_word_encoder_if.sv
// Handshake bundle for control_word_encoder: control bundle in, re-encoded opcode out,
// plus illegal-bundle counter and occupancy status.
interface control_word_encoder_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [9:0]               in_ctrl;
    logic                     out_valid;
    logic                     out_ready;
    logic [5:0]               out_opcode;
    logic                     out_illegal;
    logic                     err_clr;
    logic [CNT_W-1:0]         err_count;
    logic [$clog2(DEPTH):0]   fill;

    modport master (
        output in_valid, in_ctrl, out_ready, err_clr,
        input  in_ready, out_valid, out_opcode, out_illegal, err_count, fill
    );

    modport slave (
        input  in_valid, in_ctrl, out_ready, err_clr,
        output in_ready, out_valid, out_opcode, out_illegal, err_count, fill
    );
endinterface

// File: rtl/control_word_encoder.sv
// Re-encodes a main-decoder control bundle to its MIPS opcode into a DEPTH-entry FIFO; 1-cycle latency.
// Backpressure: in_ready = !full (state only); head entry held stable until popped.
module control_word_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_word_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [6:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_err_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_illegal;
    logic [5:0]       w_opcode;
    logic [6:0]       w_head;

    assign w_full  = (r_fill == FW'(DEPTH));
    assign w_empty = (r_fill == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.out_ready && !w_empty;

    // Exact match only: any stray bit in an unused field makes the bundle illegal.
    always_comb begin
        w_opcode  = 6'b000000;
        w_illegal = 1'b0;
        case (bus.in_ctrl)
            10'b1010000100: w_opcode = 6'b000000;
            10'b1101100000: w_opcode = 6'b100011;
            10'b0100010000: w_opcode = 6'b101011;
            10'b0000001010: w_opcode = 6'b000100;
            10'b0000000001: w_opcode = 6'b000010;
            default: begin
                w_opcode  = 6'b111111;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_illegal, w_opcode};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Clear wins over a same-cycle illegal push; count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (bus.err_clr) begin
            r_err_count <= '0;
        end else if (w_push && w_illegal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.in_ready    = !w_full;
    assign bus.out_valid   = !w_empty;
    assign bus.out_opcode  = w_empty ? 6'b000000 : w_head[5:0];
    assign bus.out_illegal = w_empty ? 1'b0 : w_head[6];
    assign bus.err_count   = r_err_count;
    assign bus.fill        = r_fill;
endmodule

// File: tb/tb_control_word_encoder.sv
module tb_control_word_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_word_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) b ();
    control_word_encoder_if #(.DEPTH(DEPTH), .CNT_W(2))     b2 ();

    control_word_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
    control_word_encoder #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [6:0] q[$];
    int         mfill = 0;
    int         merr  = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [9:0] pack(input bit reg_write, input bit alu_src, input bit reg_dst,
                                        input bit mem_to_reg, input bit mem_read, input bit mem_write,
                                        input bit branch, input logic [1:0] alu_op, input bit jump);
        return {reg_write, alu_src, reg_dst, mem_to_reg, mem_read, mem_write, branch, alu_op, jump};
    endfunction

    // Bundle each instruction class makes the main decoder emit, with its opcode.
    function automatic logic [9:0] legal_bundle(input int k);
        case (k)
            0:       return pack(1, 0, 1, 0, 0, 0, 0, 2'b10, 0);
            1:       return pack(1, 1, 0, 1, 1, 0, 0, 2'b00, 0);
            2:       return pack(0, 1, 0, 0, 0, 1, 0, 2'b00, 0);
            3:       return pack(0, 0, 0, 0, 0, 0, 1, 2'b01, 0);
            default: return pack(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        endcase
    endfunction

    function automatic logic [5:0] legal_opcode(input int k);
        case (k)
            0:       return 6'd0;
            1:       return 6'd35;
            2:       return 6'd43;
            3:       return 6'd4;
            default: return 6'd2;
        endcase
    endfunction

    function automatic logic [6:0] ref_enc(input logic [9:0] c);
        for (int k = 0; k < 5; k++) begin
            if (c == legal_bundle(k)) return {1'b0, legal_opcode(k)};
        end
        return {1'b1, 6'h3f};
    endfunction

    function automatic logic [9:0] rand_illegal();
        logic [9:0] c;
        logic [6:0] e;
        for (int t = 0; t < 100; t++) begin
            c = 10'($urandom);
            e = ref_enc(c);
            if (e[6]) return c;
        end
        return 10'b1111111111;
    endfunction

    function automatic logic [9:0] rand_ctrl();
        if ($urandom_range(1, 0) == 0) return legal_bundle(int'($urandom_range(4, 0)));
        return 10'($urandom);
    endfunction

    task automatic step(input bit v, input logic [9:0] c, input bit ordy, input bit clr);
        bit         ai;
        bit         ao;
        logic [6:0] e;
        b.in_valid  = v;
        b.in_ctrl   = c;
        b.out_ready = ordy;
        b.err_clr   = clr;
        ai = v && (mfill != DEPTH);
        ao = ordy && (mfill != 0);
        e  = ref_enc(c);
        @(posedge clk);
        if (ai) q.push_back(e);
        if (clr) merr = 0;
        else if (ai && e[6] && merr != (1 << CNT_W) - 1) merr++;
        mfill = mfill + int'(ai) - int'(ao);
        #1;
    endtask

    // Monitor: compares the head entry and status against the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(b.in_ready), int'(mfill != DEPTH));
            chk("out_valid", int'(b.out_valid), int'(mfill != 0));
            chk("fill", int'(b.fill), mfill);
            chk("err_count", int'(b.err_count), merr);
            if (mfill == 0) begin
                chk("idle_opcode", int'(b.out_opcode), 0);
                chk("idle_illegal", int'(b.out_illegal), 0);
            end else if (q.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                chk("out_opcode", int'(b.out_opcode), int'(q[0][5:0]));
                chk("out_illegal", int'(b.out_illegal), int'(q[0][6]));
                if (b.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [9:0] c;
        int         exp2;
        b.in_valid = 0;  b.in_ctrl = '0;  b.out_ready = 0;  b.err_clr = 0;
        b2.in_valid = 0; b2.in_ctrl = '0; b2.out_ready = 1; b2.err_clr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", int'(b.out_valid), 0);
        chk("rst_fill", int'(b.fill), 0);
        chk("rst_err", int'(b.err_count), 0);
        chk("rst_opcode", int'(b.out_opcode), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Legal bundles streamed with the consumer always ready.
        for (int k = 0; k < 5; k++) step(1, legal_bundle(k), 1, 0);
        step(0, '0, 1, 0);

        // Two illegal bundles, then a clear.
        step(1, 10'b1111111111, 1, 0);
        step(1, 10'b1010000101, 1, 0);
        step(0, '0, 1, 0);
        chk("err_after_two", int'(b.err_count), 2);
        step(0, '0, 1, 1);
        chk("err_after_clr", int'(b.err_count), 0);

        // Fill with consumer stalled; fifth offer must be refused.
        for (int k = 0; k < 5; k++) step(1, rand_ctrl(), 0, 0);
        chk("full_fill", int'(b.fill), DEPTH);
        chk("full_in_ready", int'(b.in_ready), 0);
        for (int k = 0; k < 4; k++) step(0, rand_ctrl(), 1, 0);
        chk("drained_fill", int'(b.fill), 0);

        // Full plus simultaneous push/pop: pop only, then steady streaming past wrap.
        for (int k = 0; k < 4; k++) step(1, rand_ctrl(), 0, 0);
        step(1, rand_ctrl(), 1, 0);
        chk("full_pushpop_fill", int'(b.fill), 3);
        for (int k = 0; k < 12; k++) step(1, rand_ctrl(), 1, 0);
        chk("stream_fill", int'(b.fill), 3);

        // Clear and illegal push in the same cycle.
        step(1, rand_illegal(), 1, 0);
        step(1, rand_illegal(), 1, 1);
        chk("clr_priority", int'(b.err_count), 0);

        // Random traffic.
        for (int k = 0; k < 300; k++)
            step(($urandom_range(3, 0) != 0), rand_ctrl(), ($urandom_range(2, 0) != 0),
                 ($urandom_range(15, 0) == 0));

        // Asynchronous reset with three entries queued.
        for (int k = 0; k < 8 && mfill != 0; k++) step(0, '0, 1, 0);
        for (int k = 0; k < 3; k++) step(1, rand_illegal(), 0, 0);
        chk("pre_reset_fill", int'(b.fill), 3);
        b.in_valid = 0;
        rst_n = 1'b0;
        q.delete();
        mfill = 0;
        merr  = 0;
        #1;
        chk("async_out_valid", int'(b.out_valid), 0);
        chk("async_fill", int'(b.fill), 0);
        chk("async_err", int'(b.err_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, legal_bundle(1), 1, 0);
        step(0, '0, 1, 0);
        for (int k = 0; k < 8 && mfill != 0; k++) step(0, '0, 1, 0);
        chk("scoreboard_empty", q.size(), 0);

        // Narrow counter saturation on the second instance.
        chk("sat_start", int'(b2.err_count), 0);
        for (int k = 0; k < 5; k++) begin
            b2.in_valid = 1;
            b2.in_ctrl  = rand_illegal();
            @(posedge clk);
            #1;
            exp2 = (k + 1 > 3) ? 3 : k + 1;
            chk("sat_err_count", int'(b2.err_count), exp2);
            chk("sat_illegal", int'(b2.out_illegal), 1);
        end
        b2.in_valid = 0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
